// File: rtl/mac_accumulate_stage.sv
// Accumulator stage (MREG + PREG) of the DSP slice: loads, adds or subtracts an unsigned product into P.
// Latency: a term captured by stage 1 lands in P/P_VALID on the next enabled edge; one term per cycle.
// Backpressure: none; CE low freezes both stages. Define MAC_PATTERN_DETECT_EN to add PATTERNDETECT.
module mac_accumulate_stage #(
    parameter int M_WIDTH   = 16,
    parameter int P_WIDTH   = 48,
    parameter int CNT_WIDTH = 8
`ifdef MAC_PATTERN_DETECT_EN
    ,
    parameter logic [P_WIDTH-1:0] PATTERN = '0
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic [M_WIDTH-1:0]   M,
    input  logic                 M_VALID,
    input  logic                 LOAD,
    input  logic                 SUB,
    output logic [P_WIDTH-1:0]   P,
    output logic                 P_VALID,
    output logic [CNT_WIDTH-1:0] ACC_COUNT,
    output logic                 OVERFLOW
`ifdef MAC_PATTERN_DETECT_EN
    ,
    output logic                 PATTERNDETECT
`endif
);

    typedef struct packed {
        logic [P_WIDTH-1:0] m_dat;
        logic               load;
        logic               sub;
        logic               vld;
    } mreg_t;

    mreg_t                mreg;
    logic [P_WIDTH-1:0]   p_base;
    logic [P_WIDTH:0]     p_ext;
    logic [P_WIDTH-1:0]   p_next;
    logic                 carry;
    logic                 ov_next;
    logic [CNT_WIDTH-1:0] cnt_next;

    // A load is just an accumulate onto zero, so its borrow falls out of the same subtractor.
    always_comb begin
        p_base = mreg.load ? '0 : P;
        if (mreg.sub) begin
            p_ext = {1'b0, p_base} - {1'b0, mreg.m_dat};
        end else begin
            p_ext = {1'b0, p_base} + {1'b0, mreg.m_dat};
        end
        p_next  = p_ext[P_WIDTH-1:0];
        carry   = p_ext[P_WIDTH];
        ov_next = mreg.load ? carry : (OVERFLOW | carry);
        if (mreg.load) begin
            cnt_next = CNT_WIDTH'(1);
        end else if (&ACC_COUNT) begin
            cnt_next = ACC_COUNT;
        end else begin
            cnt_next = ACC_COUNT + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mreg <= '0;
        end else if (CE) begin
            mreg.m_dat <= P_WIDTH'(M);
            mreg.load  <= LOAD & M_VALID;
            mreg.sub   <= SUB & M_VALID;
            mreg.vld   <= M_VALID;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P         <= '0;
            P_VALID   <= 1'b0;
            ACC_COUNT <= '0;
            OVERFLOW  <= 1'b0;
        end else if (CE) begin
            P_VALID <= mreg.vld;
            if (mreg.vld) begin
                P         <= p_next;
                ACC_COUNT <= cnt_next;
                OVERFLOW  <= ov_next;
            end
        end
    end

`ifdef MAC_PATTERN_DETECT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PATTERNDETECT <= 1'b0;
        end else if (CE && mreg.vld) begin
            PATTERNDETECT <= (p_next == PATTERN);
        end
    end
`endif

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Scoreboard bench for mac_accumulate_stage: a transaction-level model queues expected P state per term.
module tb_mac_accumulate_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CE;
    logic [15:0] M;
    logic        M_VALID;
    logic        LOAD;
    logic        SUB;
    logic [47:0] P;
    logic        P_VALID;
    logic [7:0]  ACC_COUNT;
    logic        OVERFLOW;
`ifdef MAC_PATTERN_DETECT_EN
    logic        PATTERNDETECT;
`endif

    always #5 CLK = ~CLK;

`ifdef MAC_PATTERN_DETECT_EN
    mac_accumulate_stage #(.M_WIDTH(16), .P_WIDTH(48), .CNT_WIDTH(8), .PATTERN(48'd100)) dut (
`else
    mac_accumulate_stage #(.M_WIDTH(16), .P_WIDTH(48), .CNT_WIDTH(8)) dut (
`endif
        .CLK(CLK), .RST(RST), .CE(CE), .M(M), .M_VALID(M_VALID), .LOAD(LOAD), .SUB(SUB),
        .P(P), .P_VALID(P_VALID), .ACC_COUNT(ACC_COUNT), .OVERFLOW(OVERFLOW)
`ifdef MAC_PATTERN_DETECT_EN
        , .PATTERNDETECT(PATTERNDETECT)
`endif
    );

    typedef struct {
        logic [47:0] p;
        logic [7:0]  cnt;
        logic        ov;
        logic        pd;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] mdl_p   = '0;
    int          mdl_cnt = 0;
    logic        mdl_ov  = 1'b0;
    int          checks  = 0;
    int          errors  = 0;
    logic        ce_last = 1'b0;
    logic [47:0] p_hold;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs; a term captured by stage 1 updates the model and queues its result.
    task automatic step(input logic ce, input logic vld, input logic [15:0] m,
                        input logic ld, input logic sb);
        logic [48:0] w;
        exp_t        e;
        CE = ce; M_VALID = vld; M = m; LOAD = ld; SUB = sb;
        if (ce && vld) begin
            if (ld) begin
                mdl_p   = sb ? (48'd0 - 48'(m)) : 48'(m);
                mdl_cnt = 1;
                mdl_ov  = sb && (m != 16'd0);
            end else begin
                if (sb) begin
                    if (mdl_p < 48'(m)) mdl_ov = 1'b1;
                    mdl_p = mdl_p - 48'(m);
                end else begin
                    w = {1'b0, mdl_p} + 49'(m);
                    if (w[48]) mdl_ov = 1'b1;
                    mdl_p = w[47:0];
                end
                if (mdl_cnt < 255) mdl_cnt++;
            end
            e.p   = mdl_p;
            e.cnt = 8'(mdl_cnt);
            e.ov  = mdl_ov;
            e.pd  = (mdl_p == 48'd100);
            exp_q.push_back(e);
        end
        @(negedge CLK);
    endtask

    always @(posedge CLK) ce_last <= CE;

    // A fresh result is one with P_VALID high after an enabled edge.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && ce_last && P_VALID) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_p", P, e.p);
                chk("sb_cnt", ACC_COUNT, e.cnt);
                chk("sb_ov", OVERFLOW, e.ov);
`ifdef MAC_PATTERN_DETECT_EN
                chk("sb_pd", PATTERNDETECT, e.pd);
`endif
            end
        end
    end

    initial begin
        RST = 1'b1; CE = 1'b0; M = '0; M_VALID = 1'b0; LOAD = 1'b0; SUB = 1'b0;
        #3;
        chk("rst_p", P, 0);
        chk("rst_vld", P_VALID, 0);
        chk("rst_cnt", ACC_COUNT, 0);
        chk("rst_ov", OVERFLOW, 0);
`ifdef MAC_PATTERN_DETECT_EN
        chk("rst_pd", PATTERNDETECT, 0);
`endif
        @(negedge CLK);
        RST = 1'b0;

        // Latency: stage 1 only after the first edge, P after the second.
        step(1, 1, 16'd3, 1, 0);
        chk("lat_s1_vld", P_VALID, 0);
        step(1, 0, 16'd0, 0, 0);
        chk("lat_p", P, 3);
        chk("lat_vld", P_VALID, 1);

        // Back-to-back add, subtract-through-zero, add.
        step(1, 1, 16'd5, 0, 0);
        step(1, 1, 16'd10, 0, 1);
        step(1, 1, 16'd2, 0, 0);
        step(1, 0, 16'd0, 0, 0);
        step(1, 0, 16'd0, 0, 0);
        chk("acc_p", P, 0);
        chk("acc_ov", OVERFLOW, 1);
        chk("acc_cnt", ACC_COUNT, 4);

        // CE stall with a term parked in stage 1.
        p_hold = mdl_p;
        step(1, 1, 16'd7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 16'd99, 1, 1);
            chk("stall_p", P, p_hold);
            chk("stall_vld", P_VALID, 0);
        end
        step(1, 0, 16'd0, 0, 0);
        chk("stall_rel_p", P, p_hold + 48'd7);
        step(1, 0, 16'd0, 0, 0);
        chk("stall_once_p", P, p_hold + 48'd7);
        chk("stall_once_vld", P_VALID, 0);

        // Counter saturation, then a load-subtract borrowing from zero.
        for (int i = 0; i < 300; i++) step(1, 1, 16'd1, 0, 0);
        step(1, 1, 16'd1, 1, 1);
        chk("sat_cnt", ACC_COUNT, 255);
        step(1, 0, 16'd0, 0, 0);
        step(1, 0, 16'd0, 0, 0);
        chk("ldsub_p", P, 48'hFFFF_FFFF_FFFF);
        chk("ldsub_cnt", ACC_COUNT, 1);
        chk("ldsub_ov", OVERFLOW, 1);

        // Controls without M_VALID are ignored.
        p_hold = mdl_p;
        step(1, 0, 16'd55, 1, 1);
        step(1, 0, 16'd0, 0, 0);
        step(1, 0, 16'd0, 0, 0);
        chk("bub_p", P, p_hold);
        chk("bub_vld", P_VALID, 0);
        chk("bub_cnt", ACC_COUNT, 1);

        // Reset with a term in flight.
        step(1, 1, 16'd9, 0, 0);
        #2;
        RST = 1'b1; M_VALID = 1'b0; LOAD = 1'b0; SUB = 1'b0;
        #1;
        chk("mrst_p", P, 0);
        chk("mrst_vld", P_VALID, 0);
        chk("mrst_cnt", ACC_COUNT, 0);
        chk("mrst_ov", OVERFLOW, 0);
        exp_q.delete();
        mdl_p = '0; mdl_cnt = 0; mdl_ov = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        step(1, 0, 16'd0, 0, 0);
        step(1, 0, 16'd0, 0, 0);
        chk("mrst_drop_p", P, 0);
        chk("mrst_drop_vld", P_VALID, 0);

        // Random mix of loads, adds and subtracts through the scoreboard.
        for (int i = 0; i < 60; i++) begin
            step(1, ($urandom_range(0, 3) != 0), 16'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
        end

`ifdef MAC_PATTERN_DETECT_EN
        step(1, 1, 16'd60, 1, 0);
        step(1, 1, 16'd40, 0, 0);
        step(1, 1, 16'd1, 0, 0);
        chk("pd_hit_p", P, 100);
        chk("pd_hit", PATTERNDETECT, 1);
        step(1, 0, 16'd0, 0, 0);
        chk("pd_miss_p", P, 101);
        chk("pd_miss", PATTERNDETECT, 0);
`endif

        for (int i = 0; i < 3; i++) step(1, 0, 16'd0, 0, 0);
        chk("sb_drain", 64'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
